// File: rtl/water_reminder_timer.sv
// Water reminder timer: 24-hour time of day plus a drink-water reminder FSM.
// Counts seconds from the divider's slow tick, raises and tracks reminders.
//
// Ports:
//   clk          system clock (also drives the upstream divider)
//   reset        asynchronous, active-low reset
//   tick         slow square wave, synchronous to clk; each rising edge = 1 s
//   enable       reminder enable (level)
//   ack          "drank water" pulse, debounced upstream
//   snooze       snooze pulse, debounced upstream
//   hours        0..23
//   minutes      0..59
//   seconds      0..59
//   remind       high while an alert is up
//   missed_count consecutive missed reminders, saturates at 15
//   remaining    seconds left in a countdown or snooze period, else 0

module water_reminder_timer #(
    parameter int unsigned INTERVAL_MIN    = 60,
    parameter int unsigned SNOOZE_MIN      = 10,
    parameter int unsigned ALERT_TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        enable,
    input  logic        ack,
    input  logic        snooze,
    output logic [4:0]  hours,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic        remind,
    output logic [3:0]  missed_count,
    output logic [15:0] remaining
);

    localparam logic [15:0] IVL_S  = 16'(INTERVAL_MIN * 60);
    localparam logic [15:0] SNZ_S  = 16'(SNOOZE_MIN * 60);
    localparam logic [15:0] TO_M1  = 16'(ALERT_TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_ALERT,
        S_SNOOZE
    } state_t;

    state_t      state;
    state_t      state_d;
    logic        tick_q;
    logic        sec_p;
    logic [15:0] atmr;
    logic [15:0] atmr_d;
    logic [15:0] rem_d;
    logic [3:0]  miss_d;
    logic        remind_d;

    // tick_q resets high so a tick already high at release is not a second
    assign sec_p = tick & ~tick_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b1;
        end else begin
            tick_q <= tick;
        end
    end

    // Time of day, independent of the reminder logic
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hours   <= 5'd0;
            minutes <= 6'd0;
            seconds <= 6'd0;
        end else if (sec_p) begin
            if (seconds == 6'd59) begin
                seconds <= 6'd0;
                if (minutes == 6'd59) begin
                    minutes <= 6'd0;
                    if (hours == 5'd23) begin
                        hours <= 5'd0;
                    end else begin
                        hours <= hours + 5'd1;
                    end
                end else begin
                    minutes <= minutes + 6'd1;
                end
            end else begin
                seconds <= seconds + 6'd1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            remaining    <= 16'd0;
            atmr         <= 16'd0;
            missed_count <= 4'd0;
            remind       <= 1'b0;
        end else begin
            state        <= state_d;
            remaining    <= rem_d;
            atmr         <= atmr_d;
            missed_count <= miss_d;
            remind       <= remind_d;
        end
    end

    // Next state and datapath; a reload overrides any same-cycle decrement
    always_comb begin
        state_d = state;
        rem_d   = remaining;
        atmr_d  = atmr;
        miss_d  = missed_count;
        if (!enable) begin
            state_d = S_IDLE;
            rem_d   = 16'd0;
            atmr_d  = 16'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_d = S_COUNT;
                    rem_d   = IVL_S;
                end
                S_COUNT: begin
                    if (sec_p) begin
                        if (remaining == 16'd1) begin
                            state_d = S_ALERT;
                            rem_d   = 16'd0;
                            atmr_d  = 16'd0;
                        end else if (remaining != 16'd0) begin
                            rem_d = remaining - 16'd1;
                        end
                    end
                end
                S_ALERT: begin
                    if (ack) begin
                        state_d = S_COUNT;
                        rem_d   = IVL_S;
                        miss_d  = 4'd0;
                    end else if (snooze) begin
                        state_d = S_SNOOZE;
                        rem_d   = SNZ_S;
                    end else if (sec_p) begin
                        if (atmr == TO_M1) begin
                            state_d = S_COUNT;
                            rem_d   = IVL_S;
                            atmr_d  = 16'd0;
                            if (missed_count != 4'd15) begin
                                miss_d = missed_count + 4'd1;
                            end
                        end else begin
                            atmr_d = atmr + 16'd1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (ack) begin
                        state_d = S_COUNT;
                        rem_d   = IVL_S;
                        miss_d  = 4'd0;
                    end else if (sec_p) begin
                        if (remaining == 16'd1) begin
                            state_d = S_ALERT;
                            rem_d   = 16'd0;
                            atmr_d  = 16'd0;
                        end else if (remaining != 16'd0) begin
                            rem_d = remaining - 16'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    rem_d   = 16'd0;
                    atmr_d  = 16'd0;
                end
            endcase
        end
    end

    // remind is registered from the next state so it tracks ALERT exactly
    always_comb begin
        remind_d = (state_d == S_ALERT);
    end

endmodule

// File: tb/tb_water_reminder_timer.sv
// Bench for water_reminder_timer: directed scenarios plus random traffic,
// every clock checked against a seconds-of-day / mode-name reference model.

module tb_water_reminder_timer;

    localparam int IVS = 60;
    localparam int SVS = 60;
    localparam int TO  = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        enable;
    logic        ack;
    logic        snooze;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic        remind;
    logic [3:0]  missed_count;
    logic [15:0] remaining;

    water_reminder_timer #(
        .INTERVAL_MIN(1),
        .SNOOZE_MIN(1),
        .ALERT_TIMEOUT_S(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .enable(enable),
        .ack(ack),
        .snooze(snooze),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .remind(remind),
        .missed_count(missed_count),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tag;
        int h;
        int m;
        int s;
        bit rmd;
        int miss;
        int rem;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int passes = 0;

    // Reference model: time as seconds-of-day, reminder as a named mode
    int    m_t;
    string m_mode;
    int    m_rem;
    int    m_alert_secs;
    int    m_miss;
    bit    m_tq;
    logic  en_lvl;

    function automatic void model_reset();
        m_t          = 0;
        m_mode       = "idle";
        m_rem        = 0;
        m_alert_secs = 0;
        m_miss       = 0;
        m_tq         = 1'b1;
    endfunction

    function automatic void to_count();
        m_mode = "count";
        m_rem  = IVS;
    endfunction

    function automatic void countdown();
        if (m_rem > 1) begin
            m_rem = m_rem - 1;
        end else if (m_rem == 1) begin
            m_mode       = "alert";
            m_rem        = 0;
            m_alert_secs = 0;
        end
    endfunction

    function automatic void model_edge(bit t, bit e, bit a, bit s);
        bit sp;
        sp   = t && !m_tq;
        m_tq = t;
        if (sp) m_t = (m_t + 1) % 86400;
        if (!e) begin
            m_mode = "idle";
            m_rem  = 0;
            return;
        end
        if (m_mode == "idle") begin
            to_count();
        end else if (m_mode == "count") begin
            if (sp) countdown();
        end else if (m_mode == "alert") begin
            if (a) begin
                to_count();
                m_miss = 0;
            end else if (s) begin
                m_mode = "snooze";
                m_rem  = SVS;
            end else if (sp) begin
                m_alert_secs = m_alert_secs + 1;
                if (m_alert_secs == TO) begin
                    to_count();
                    m_miss = (m_miss < 15) ? m_miss + 1 : 15;
                end
            end
        end else begin
            if (a) begin
                to_count();
                m_miss = 0;
            end else if (sp) begin
                countdown();
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.tag  = cyc;
        e.h    = m_t / 3600;
        e.m    = (m_t / 60) % 60;
        e.s    = m_t % 60;
        e.rmd  = (m_mode == "alert");
        e.miss = m_miss;
        e.rem  = m_rem;
        sb.push_back(e);
    endfunction

    // Monitor: compares every expectation due by this falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (int'(hours) == e.h && int'(minutes) == e.m &&
                int'(seconds) == e.s && remind == e.rmd &&
                int'(missed_count) == e.miss &&
                int'(remaining) == e.rem) begin
                passes++;
            end else begin
                $display("FAIL outputs cyc=%0d got %0d:%0d:%0d rmd=%0b miss=%0d rem=%0d exp %0d:%0d:%0d rmd=%0b miss=%0d rem=%0d",
                         cyc, hours, minutes, seconds, remind,
                         missed_count, remaining, e.h, e.m, e.s,
                         e.rmd, e.miss, e.rem);
            end
        end
    end

    task automatic cyc1(input logic t, input logic e,
                        input logic a, input logic s);
        tick   = t;
        enable = e;
        ack    = a;
        snooze = s;
        @(posedge clk);
        #1;
        if (!reset) model_reset();
        else model_edge(t, e, a, s);
        push_exp();
    endtask

    task automatic sec(input int hi, input int lo,
                       input logic a, input logic s);
        for (int i = 0; i < hi; i++)
            cyc1(1'b1, en_lvl, (i == 0) ? a : 1'b0, (i == 0) ? s : 1'b0);
        for (int i = 0; i < lo; i++)
            cyc1(1'b0, en_lvl, 1'b0, 1'b0);
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) sec(2, 2, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic a, input logic s);
        cyc1(1'b0, en_lvl, a, s);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge
    task automatic async_reset(input int n);
        reset = 1'b0;
        #1;
        model_reset();
        if (sb.size() > 0) void'(sb.pop_back());
        push_exp();
        for (int i = 0; i < n; i++) cyc1(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        tick   = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        snooze = 1'b0;
        en_lvl = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cyc1(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc1(1'b1, 1'b0, 1'b0, 1'b0);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0);
        cyc1(1'b0, 1'b0, 1'b0, 1'b0);

        // Timekeeping through minute and hour carries
        secs(3661);

        // Countdown into the first alert
        en_lvl = 1'b1;
        pulse(1'b0, 1'b0);
        secs(60);

        // Snooze, re-alert, acknowledge
        pulse(1'b0, 1'b1);
        secs(60);
        pulse(1'b1, 1'b0);

        // ack and snooze together on the timeout second
        secs(60);
        secs(4);
        sec(2, 2, 1'b1, 1'b1);

        // Unanswered alerts until missed_count saturates
        for (int k = 0; k < 17; k++) begin
            secs(60);
            secs(5);
        end

        // Reset mid-alert, release with tick high
        secs(60);
        secs(2);
        async_reset(3);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0);
        cyc1(1'b1, 1'b0, 1'b0, 1'b0);
        cyc1(1'b0, 1'b0, 1'b0, 1'b0);
        en_lvl = 1'b0;
        secs(1);

        // Drop enable while snoozed
        en_lvl = 1'b1;
        pulse(1'b0, 1'b0);
        secs(60);
        pulse(1'b0, 1'b1);
        secs(3);
        en_lvl = 1'b0;
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);

        // Random traffic
        en_lvl = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            sec($urandom_range(1, 3), $urandom_range(1, 3),
                logic'($urandom_range(0, 24) == 0),
                logic'($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 14) == 0)
                pulse(logic'($urandom_range(0, 1)),
                      logic'($urandom_range(0, 1)));
            if ($urandom_range(0, 299) == 0) en_lvl = ~en_lvl;
            if (!en_lvl && $urandom_range(0, 4) == 0) en_lvl = 1'b1;
        end

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain left=%0d exp 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
